// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter: XGA geometry,
// framebuffer widths and the blanking classification used by the arbiter FSM.
package vga_fb_arbiter_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
  localparam int FB_ADDR_W  = 20;
  localparam int FB_DATA_W  = 12;
  localparam int TIMING_W   = 26;
  localparam int PIPE_DEL   = 3;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HBLANK = 2'd1,
    ST_VBLANK = 2'd2
  } fb_state_t;

  // Vertical blanking dominates horizontal blanking.
  function automatic fb_state_t classify(input logic hblnk, input logic vblnk);
    fb_state_t st;
    if (vblnk) begin
      st = ST_VBLANK;
    end else if (hblnk) begin
      st = ST_HBLANK;
    end else begin
      st = ST_ACTIVE;
    end
    return st;
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-latency register pipeline; keeps the timing signals aligned with
// the pixel data returned from the framebuffer.
module vga_delay #(
  parameter int WIDTH   = 26,
  parameter int CLK_DEL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [CLK_DEL];

  // Shift register, stage 0 samples the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[CLK_DEL-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer owner: scan-out reads during active video, writer
// served in blanking, double-buffered with the page flip taken at vblank entry.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int H_ACTIVE   = HOR_PIXELS,
  parameter int V_ACTIVE   = VER_PIXELS,
  parameter int PIX_ADDR_W = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [DATA_W-1:0]     rgb_out,
  input  logic                  wr_req,
  input  logic [PIX_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ack,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_sel,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [PIX_ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned PIX_COUNT = H_ACTIVE * V_ACTIVE;
  localparam logic [PIX_ADDR_W-1:0] PIX_LAST = PIX_ADDR_W'(PIX_COUNT - 1);

  fb_state_t             state_r;
  logic [PIX_ADDR_W-1:0] rd_ptr_r;
  logic                  swap_pend_r;
  logic                  active_d1_r;
  logic                  active_d2_r;
  logic                  active_s;
  logic                  in_range_s;
  logic                  vblank_entry_s;
  logic                  flip_s;
  logic [TIMING_W-1:0]   timing_in_s;
  logic [TIMING_W-1:0]   timing_out_s;

  // Slot classification and writer handshake, all from the current inputs.
  always_comb begin
    active_s       = !hblnk_in && !vblnk_in;
    in_range_s     = (wr_addr <= PIX_LAST);
    vblank_entry_s = (state_r != ST_VBLANK) && vblnk_in;
    flip_s         = vblank_entry_s && (swap_pend_r || swap_req);
    wr_ack         = rst_n && !active_s && wr_req;
  end

  // Arbiter FSM, read pointer, page flip and registered RAM request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_VBLANK;
      rd_ptr_r    <= {PIX_ADDR_W{1'b0}};
      swap_pend_r <= 1'b0;
      front_sel   <= 1'b0;
      swap_done   <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {(PIX_ADDR_W+1){1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
    end else begin
      state_r <= classify(hblnk_in, vblnk_in);

      if (vblnk_in) begin
        rd_ptr_r <= {PIX_ADDR_W{1'b0}};
      end else if (active_s && (rd_ptr_r != PIX_LAST)) begin
        rd_ptr_r <= rd_ptr_r + PIX_ADDR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end

      // A request arriving in the entry cycle is consumed by this flip.
      if (flip_s) begin
        front_sel   <= ~front_sel;
        swap_pend_r <= 1'b0;
        swap_done   <= 1'b1;
      end else begin
        swap_pend_r <= swap_pend_r | swap_req;
        swap_done   <= 1'b0;
      end

      if (active_s) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {front_sel, rd_ptr_r};
      end else if (wr_req && in_range_s) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {~front_sel, wr_addr};
        mem_wdata <= wr_data;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

  // Data path: blank the pixel unless its sample was in active video.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_d1_r <= 1'b0;
      active_d2_r <= 1'b0;
      rgb_out     <= {DATA_W{1'b0}};
    end else begin
      active_d1_r <= active_s;
      active_d2_r <= active_d1_r;
      rgb_out     <= active_d2_r ? mem_rdata : {DATA_W{1'b0}};
    end
  end

  assign timing_in_s = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  vga_delay #(
    .WIDTH   (TIMING_W),
    .CLK_DEL (PIPE_DEL)
  ) u_timing_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (timing_in_s),
    .dout  (timing_out_s)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = timing_out_s;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: compressed raster (1024 active + 16 blank per line),
// behavioural framebuffer RAM, reference pixel model and 3-deep output scoreboard.
module tb_vga_fb_arbiter;

  localparam int HT     = 1040;
  localparam int MAXPIX = 786432;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out, wr_data, mem_wdata, mem_rdata;
  logic        wr_req, wr_ack, swap_req, swap_done, front_sel, mem_en, mem_we;
  logic [19:0] wr_addr;
  logic [20:0] mem_addr;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Preload image: buffer 0 holds addr[11:0], buffer 1 its complement.
  function automatic logic [11:0] pat(input logic [20:0] a);
    return a[11:0] ^ {12{a[20]}};
  endfunction

  bit [11:0] ram     [0:2097151];
  bit        wr_mark [0:2097151];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        wr_mark[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wr_mark[mem_addr] ? ram[mem_addr] : pat(mem_addr);
      end
    end
  end

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        fr;
  } sb_t;

  typedef struct {
    logic        hb, vb, req;
    logic [19:0] addr;
    logic [11:0] data;
    logic        exp_ack, exp_en, exp_we;
    logic [20:0] exp_addr;
    logic [11:0] exp_wdata;
  } vec_t;

  sb_t       sbq[$];
  bit [11:0] shadow[int];
  int        tot = 0, bad = 0;
  logic      front_m, pend_m, st_vb_m, last_ack;
  int        ptr_m, ack_cnt, done_cnt, first_ack_h, first_done_h, first_done_v;
  logic [20:0] last_addr_m;
  logic [11:0] last_wdata_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_pix(input logic [20:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return pat(a);
  endfunction

  task automatic reset_model();
    front_m = 1'b0; pend_m = 1'b0; st_vb_m = 1'b1; ptr_m = 0;
    last_addr_m = 21'd0; last_wdata_m = 12'd0;
    sbq.delete();
  endtask

  // One pixel clock: check the oldest scoreboard entry, drive, model, check registered outputs.
  task automatic cycle(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic req, input logic [19:0] addr,
                       input logic [11:0] data, input logic swp);
    sb_t  e;
    logic act, flip, exp_en, exp_we;
    if (sbq.size() == 3) begin
      e = sbq.pop_front();
      chk("hcount_out", 32'(hcount_out), 32'(e.h));
      chk("vcount_out", 32'(vcount_out), 32'(e.v));
      chk("sync_blank_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'({e.hs, e.vs, e.hb, e.vb}));
      chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
      if (e.h == 11'd5 && e.v == 11'd2 && !e.hb && !e.vb && !e.fr)
        chk("pix_h5_v2", 32'(rgb_out), 32'h805);
      if (hblnk_out || vblnk_out) chk("rgb_blank", 32'(rgb_out), 32'd0);
    end
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; wr_req = req; wr_addr = addr; wr_data = data; swap_req = swp;
    act = !hb && !vb;
    #1;
    last_ack = wr_ack;
    chk("wr_ack", 32'(wr_ack), 32'(req && !act));
    if (wr_ack) begin
      ack_cnt++;
      if (first_ack_h < 0) first_ack_h = int'(h);
    end
    sbq.push_back('{h: h, v: v, hs: hs, vs: vs, hb: hb, vb: vb, fr: front_m,
                    rgb: act ? ref_pix({front_m, 20'(ptr_m)}) : 12'd0});
    if (act) begin
      exp_en = 1'b1; exp_we = 1'b0; last_addr_m = {front_m, 20'(ptr_m)};
    end else if (req && (int'(addr) < MAXPIX)) begin
      exp_en = 1'b1; exp_we = 1'b1; last_addr_m = {~front_m, addr}; last_wdata_m = data;
      shadow[int'({~front_m, addr})] = data;
    end else begin
      exp_en = 1'b0; exp_we = 1'b0;
    end
    if (vb) ptr_m = 0;
    else if (act && ptr_m < MAXPIX - 1) ptr_m++;
    flip = !st_vb_m && vb && (pend_m || swp);
    if (flip) begin
      front_m = ~front_m; pend_m = 1'b0;
    end else begin
      pend_m = pend_m || swp;
    end
    st_vb_m = vb;
    @(posedge clk);
    @(negedge clk);
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_addr", 32'(mem_addr), 32'(last_addr_m));
    chk("mem_wdata", 32'(mem_wdata), 32'(last_wdata_m));
    chk("swap_done", 32'(swap_done), 32'(flip));
    chk("front_sel", 32'(front_sel), 32'(front_m));
    if (swap_done) begin
      done_cnt++;
      if (first_done_v < 0) begin first_done_h = int'(h); first_done_v = int'(v); end
    end
  endtask

  // One compressed raster line with an optional write burst and swap pulse.
  task automatic run_line(input logic [10:0] v, input logic vb, input int wr_from, input int wr_cnt,
                          input logic [19:0] wr_base, input int swap_at);
    int          done;
    logic        req, hb;
    logic [19:0] a;
    done = 0; ack_cnt = 0; first_ack_h = -1;
    for (int h = 0; h < HT; h++) begin
      hb  = (h >= 1024);
      req = (done < wr_cnt) && (h >= wr_from);
      a   = wr_base + 20'(done);
      cycle(11'(h), v, (h >= 1032) && (h < 1040), v == 11'd770, hb, vb, req, a,
            12'(a) ^ 12'h3C3, h == swap_at);
      if (req && (hb || vb)) done++;
    end
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 20'd5,      12'hABC, 1'b1, 1'b1, 1'b1, 21'h100005, 12'hABC};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 20'd786432, 12'h111, 1'b1, 1'b0, 1'b0, 21'h100005, 12'hABC};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 20'd0,      12'h000, 1'b0, 1'b0, 1'b0, 21'h100005, 12'hABC};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 20'd7,      12'h777, 1'b0, 1'b1, 1'b0, 21'h000000, 12'hABC};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 20'd7,      12'h777, 1'b0, 1'b1, 1'b0, 21'h000001, 12'hABC};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 20'd9,      12'h234, 1'b1, 1'b1, 1'b1, 21'h100009, 12'h234};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 20'd786431, 12'h345, 1'b1, 1'b1, 1'b1, 21'h1BFFFF, 12'h345};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 20'hFFFFF,  12'h456, 1'b1, 1'b0, 1'b0, 21'h1BFFFF, 12'h345};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 20'd0,      12'h000, 1'b0, 1'b1, 1'b0, 21'h000002, 12'h345};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 20'd0,      12'h000, 1'b0, 1'b0, 1'b0, 21'h000002, 12'h345};

    done_cnt = 0; first_done_h = -1; first_done_v = -1; ack_cnt = 0; first_ack_h = -1;
    reset_model();
    rst_n = 1'b0;
    hcount_in = 11'd500; vcount_in = 11'd300; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b1; wr_req = 1'b1; wr_addr = 20'd3; wr_data = 12'h0F0;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_front", 32'(front_sel), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle(11'(1100 + i), 11'd790, 1'b0, 1'b0, tbl[i].hb, tbl[i].vb, tbl[i].req,
            tbl[i].addr, tbl[i].data, 1'b0);
      chk("tbl_ack", 32'(last_ack), 32'(tbl[i].exp_ack));
      chk("tbl_en", 32'(mem_en), 32'(tbl[i].exp_en));
      chk("tbl_we", 32'(mem_we), 32'(tbl[i].exp_we));
      chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].exp_addr));
      chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].exp_wdata));
    end

    // Frame A: readout of buffer 0, 10-write burst into buffer 1.
    run_line(11'd768, 1'b1, 0, 0, 20'd0, -1);
    run_line(11'd0, 1'b0, 1024, 10, 20'd0, -1);
    chk("burst_acks", 32'(ack_cnt), 32'd10);
    run_line(11'd1, 1'b0, 0, 0, 20'd0, -1);
    run_line(11'd2, 1'b0, 0, 0, 20'd0, -1);
    run_line(11'd768, 1'b1, 0, 0, 20'd0, -1);
    run_line(11'd769, 1'b1, 0, 0, 20'd0, -1);

    // Frame B: stalled write, swap request, flip, out-of-range write.
    done_cnt = 0; first_done_h = -1; first_done_v = -1;
    run_line(11'd10, 1'b0, 100, 1, 20'd1234, -1);
    chk("stall_acks", 32'(ack_cnt), 32'd1);
    chk("stall_ack_h", 32'(first_ack_h), 32'd1024);
    run_line(11'd100, 1'b0, 0, 0, 20'd0, 0);
    chk("front_before_flip", 32'(front_sel), 32'd0);
    run_line(11'd768, 1'b1, 0, 0, 20'd0, -1);
    run_line(11'd769, 1'b1, 0, 1, 20'd786432, -1);
    chk("range_acks", 32'(ack_cnt), 32'd1);
    run_line(11'd770, 1'b1, 0, 0, 20'd0, -1);
    chk("swap_done_pulses", 32'(done_cnt), 32'd1);
    chk("flip_at_v", 32'(first_done_v), 32'd768);
    chk("flip_at_h", 32'(first_done_h), 32'd0);
    chk("front_after_flip", 32'(front_sel), 32'd1);

    // Frame C: reads from buffer 1 (burst data visible), writes land in buffer 0.
    run_line(11'd0, 1'b0, 1024, 10, 20'd0, -1);
    chk("burst2_acks", 32'(ack_cnt), 32'd10);
    run_line(11'd1, 1'b0, 0, 0, 20'd0, -1);
    run_line(11'd2, 1'b0, 0, 0, 20'd0, -1);
    run_line(11'd768, 1'b1, 0, 0, 20'd0, -1);

    // Asynchronous reset in the middle of an active line.
    for (int h = 0; h <= 500; h++)
      cycle(11'(h), 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 12'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hcount", 32'(hcount_out), 32'd0);
    chk("mid_rst_vcount", 32'(vcount_out), 32'd0);
    chk("mid_rst_rgb", 32'(rgb_out), 32'd0);
    chk("mid_rst_mem", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_front", 32'(front_sel), 32'd0);
    chk("mid_rst_swap_done", 32'(swap_done), 32'd0);
    chk("mid_rst_wr_ack", 32'(wr_ack), 32'd0);
    @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    for (int h = 501; h < HT; h++)
      cycle(11'(h), 11'd300, 1'b0, 1'b0, h >= 1024, 1'b0, 1'b0, 20'd0, 12'd0, 1'b0);
    run_line(11'd768, 1'b1, 0, 0, 20'd0, -1);
    run_line(11'd0, 1'b0, 0, 0, 20'd0, -1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
